// File: rtl/dadda_mac_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mac_pkg
// Shared definitions for the dadda_mac_pipe multiply-accumulate block:
//   - parameter range limits for WIDTH / PIPE / GUARD
//   - acc_width(): accumulator width derivation (2*WIDTH + GUARD)
//   - dadda_stage_count() / dadda_height(): Dadda reduction schedule
//   - stage_ctrl_t: control part of every pipeline stage payload
// -----------------------------------------------------------------------------
package mac_pkg;

  localparam int WIDTH_MIN = 4;
  localparam int WIDTH_MAX = 32;
  localparam int PIPE_MIN  = 0;
  localparam int PIPE_MAX  = 4;
  localparam int GUARD_MIN = 1;

  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

  // Number of Dadda reduction stages needed for a matrix of height h:
  // count of heights d_j (d_0 = 2, d_j+1 = floor(1.5 * d_j)) below h.
  function automatic int dadda_stage_count(input int h);
    int n;
    int d;
    n = 0;
    d = 2;
    while (d < h) begin
      n++;
      d = (d * 3) / 2;
    end
    return n;
  endfunction

  // Target column height after reduction stage s (s = 0 is the last stage).
  function automatic int dadda_height(input int s);
    int d;
    d = 2;
    for (int i = 0; i < s; i++) d = (d * 3) / 2;
    return d;
  endfunction

  // Control bits carried by every stage. The data field differs per stage
  // (operands in S0, extended product afterwards) and its width depends on
  // module parameters, so each module wraps this in its own payload struct.
  typedef struct packed {
    logic valid;
    logic is_signed;
    logic acc_en;
  } stage_ctrl_t;

endpackage

// File: rtl/dadda_mac_pipe_if.sv
// -----------------------------------------------------------------------------
// dadda_mac_pipe_if
// Valid/ready bus between operand fetch, the MAC pipe and write-back.
//   in_valid / in_ready      : input handshake
//   a, b                     : WIDTH-bit operands
//   is_signed                : 1 = two's complement operands, 0 = unsigned
//   acc_en                   : 1 = accumulate, 0 = load product
//   out_valid / out_ready    : output handshake
//   y                        : ACC_W-bit accumulator value
//   ovf                      : this result wrapped the accumulator
// master drives operands/out_ready, slave (the MAC) drives in_ready/results.
// -----------------------------------------------------------------------------
interface dadda_mac_pipe_if
  import mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GUARD = 4
);
  localparam int ACC_W = acc_width(WIDTH, GUARD);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             is_signed;
  logic             acc_en;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] y;
  logic             ovf;

  modport master (
    output in_valid, a, b, is_signed, acc_en, out_ready,
    input  in_ready, out_valid, y, ovf
  );

  modport slave (
    input  in_valid, a, b, is_signed, acc_en, out_ready,
    output in_ready, out_valid, y, ovf
  );

endinterface

// File: rtl/dadda_mac_pipe_mul_core.sv
// -----------------------------------------------------------------------------
// dadda_mul_core
// Purely combinational (WIDTH+1)x(WIDTH+1) two's complement multiplier.
// Operands are sign- or zero-extended by one bit, partial products are formed
// Baugh-Wooley style, reduced to two rows by a Dadda tree and summed by a
// final carry-propagate adder. The low 2*WIDTH bits are exact in both modes.
//   a_i, b_i     : WIDTH-bit operands
//   is_signed_i  : 1 = sign-extend operands, 0 = zero-extend
//   p_o          : 2*WIDTH-bit product
// -----------------------------------------------------------------------------
module dadda_mul_core
  import mac_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  input  logic               is_signed_i,
  output logic [2*WIDTH-1:0] p_o
);

  localparam int N    = WIDTH + 1;      // extended operand width
  localparam int CW   = 2 * N;          // matrix columns
  localparam int MAXH = N + 1;          // column storage depth
  localparam int PW   = 2 * WIDTH;
  localparam int OW   = $clog2(N);
  localparam int IW   = $clog2(MAXH);
  localparam int CIW  = $clog2(CW);
  localparam int NSTG = dadda_stage_count(N);

  // Index casts keep every select exactly as wide as its target.
  function automatic logic [OW-1:0] opi(input int i);
    return OW'(i);
  endfunction
  function automatic logic [IW-1:0] rwi(input int i);
    return IW'(i);
  endfunction
  function automatic logic [CIW-1:0] cli(input int i);
    return CIW'(i);
  endfunction

  logic [N-1:0]    ax;
  logic [N-1:0]    bx;
  logic [MAXH-1:0] cur [CW];
  logic [MAXH-1:0] nxt [CW];
  int              cur_cnt [CW];
  int              nxt_cnt [CW];
  int              k;
  int              h;
  int              tgt;
  logic            pp;
  logic            fx, fy, fz, fs, fc;
  logic [PW-1:0]   row0;
  logic [PW-1:0]   row1;

  // Column heights are fixed by WIDTH, so every loop below unrolls into a
  // static tree of full/half adders; only the bit values are data dependent.
  always_comb begin
    // NOTE: every variable gets a default before any conditional write so the
    // block is purely combinational and no latch is inferred.
    ax      = {is_signed_i & a_i[WIDTH-1], a_i};
    bx      = {is_signed_i & b_i[WIDTH-1], b_i};
    cur     = '{default: '0};
    nxt     = '{default: '0};
    cur_cnt = '{default: 0};
    nxt_cnt = '{default: 0};
    k       = 0;
    h       = 0;
    tgt     = 0;
    pp      = 1'b0;
    fx      = 1'b0;
    fy      = 1'b0;
    fz      = 1'b0;
    fs      = 1'b0;
    fc      = 1'b0;
    row0    = '0;
    row1    = '0;

    // Baugh-Wooley matrix: products involving exactly one sign bit are
    // inverted, and constant ones at columns N and 2N-1 correct the sum.
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        pp = ax[opi(j)] & bx[opi(i)];
        if ((i == N - 1) != (j == N - 1)) pp = ~pp;
        cur[cli(i + j)][rwi(cur_cnt[cli(i + j)])] = pp;
        cur_cnt[cli(i + j)] = cur_cnt[cli(i + j)] + 1;
      end
    end
    cur[cli(N)][rwi(cur_cnt[cli(N)])] = 1'b1;
    cur_cnt[cli(N)] = cur_cnt[cli(N)] + 1;
    cur[cli(CW - 1)][rwi(cur_cnt[cli(CW - 1)])] = 1'b1;
    cur_cnt[cli(CW - 1)] = cur_cnt[cli(CW - 1)] + 1;

    // Dadda stages, LSB to MSB per stage. h is the height column c will have
    // in the next matrix: unconsumed bits plus sums/carries already placed.
    for (int s = NSTG - 1; s >= 0; s--) begin
      tgt     = dadda_height(s);
      nxt     = '{default: '0};
      nxt_cnt = '{default: 0};
      for (int c = 0; c < CW; c++) begin
        k = 0;
        for (int r = 0; r < MAXH; r++) begin
          h = cur_cnt[cli(c)] - k + nxt_cnt[cli(c)];
          if (h > tgt && cur_cnt[cli(c)] - k >= 2) begin
            fx = cur[cli(c)][rwi(k)];
            fy = cur[cli(c)][rwi(k + 1)];
            if (h - tgt >= 2 && cur_cnt[cli(c)] - k >= 3) begin
              fz = cur[cli(c)][rwi(k + 2)];
              fs = fx ^ fy ^ fz;
              fc = (fx & fy) | (fx & fz) | (fy & fz);
              k  = k + 3;
            end else begin
              fs = fx ^ fy;
              fc = fx & fy;
              k  = k + 2;
            end
            nxt[cli(c)][rwi(nxt_cnt[cli(c)])] = fs;
            nxt_cnt[cli(c)] = nxt_cnt[cli(c)] + 1;
            if (c + 1 < CW) begin
              nxt[cli(c + 1)][rwi(nxt_cnt[cli(c + 1)])] = fc;
              nxt_cnt[cli(c + 1)] = nxt_cnt[cli(c + 1)] + 1;
            end
          end
        end
        // Bits not consumed by an adder pass straight to the next matrix.
        for (int r = 0; r < MAXH; r++) begin
          if (r >= k && r < cur_cnt[cli(c)]) begin
            nxt[cli(c)][rwi(nxt_cnt[cli(c)])] = cur[cli(c)][rwi(r)];
            nxt_cnt[cli(c)] = nxt_cnt[cli(c)] + 1;
          end
        end
      end
      cur     = nxt;
      cur_cnt = nxt_cnt;
    end

    // At most two bits per column remain; columns above PW are not needed.
    for (int c = 0; c < PW; c++) begin
      row0[c] = (cur_cnt[cli(c)] > 0) ? cur[cli(c)][rwi(0)] : 1'b0;
      row1[c] = (cur_cnt[cli(c)] > 1) ? cur[cli(c)][rwi(1)] : 1'b0;
    end
  end

  assign p_o = row0 + row1;

endmodule

// File: rtl/dadda_mac_pipe.sv
// -----------------------------------------------------------------------------
// dadda_mac_pipe
// Pipelined signed/unsigned WIDTH x WIDTH multiplier with a guarded
// accumulator and full valid/ready backpressure.
//   S0  : input register (operands, mode bits, valid)
//   S1..S(PIPE): registered, extended product P
//   SO  : accumulator / output register (y, ovf, out_valid)
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : dadda_mac_pipe_if slave (handshakes, operands, results)
// in_ready is the only combinational output (it follows out_ready).
// -----------------------------------------------------------------------------
module dadda_mac_pipe
  import mac_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int PIPE  = 1,
  parameter int GUARD = 4
) (
  input logic              clk,
  input logic              rst,
  dadda_mac_pipe_if.slave  bus
);

  localparam int ACC_W = acc_width(WIDTH, GUARD);
  localparam int PW    = 2 * WIDTH;

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } s0_t;

  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [ACC_W-1:0] p;
  } sp_t;

  logic             stall;
  s0_t              s0_d;
  s0_t              s0_q;
  logic [PW-1:0]    prod;
  sp_t              prod_entry;
  sp_t              so_in;
  logic [ACC_W-1:0] acc_d;
  logic [ACC_W-1:0] acc_q;
  logic             ovf_d;
  logic             ovf_q;
  logic             out_valid_d;
  logic             out_valid_q;
  logic [ACC_W:0]   sum;

  // A held output freezes the whole pipe; there is no bubble collapsing.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign bus.in_ready = ~stall;

  // S0 loads every unstalled cycle; in_valid=0 simply inserts a bubble.
  always_comb begin
    s0_d.ctrl.valid     = bus.in_valid;
    s0_d.ctrl.is_signed = bus.is_signed;
    s0_d.ctrl.acc_en    = bus.acc_en;
    s0_d.a              = bus.a;
    s0_d.b              = bus.b;
  end

  always_ff @(posedge clk) begin
    // NOTE: only valid bits are reset; payload is don't-care while invalid.
    if (rst) begin
      s0_q.ctrl.valid <= 1'b0;
    end else if (!stall) begin
      // NOTE: state registers use non-blocking assignment so all stages
      // sample the pre-edge values and shift by exactly one.
      s0_q <= s0_d;
    end
  end

  dadda_mul_core #(
    .WIDTH (WIDTH)
  ) u_mul (
    .a_i         (s0_q.a),
    .b_i         (s0_q.b),
    .is_signed_i (s0_q.ctrl.is_signed),
    .p_o         (prod)
  );

  // Extend the exact 2*WIDTH product into the guard bits per entry mode.
  always_comb begin
    prod_entry.ctrl = s0_q.ctrl;
    prod_entry.p    = {{GUARD{s0_q.ctrl.is_signed & prod[PW-1]}}, prod};
  end

  if (PIPE == 0) begin : g_no_pipe
    assign so_in = prod_entry;
  end else begin : g_pipe
    sp_t pipe_q [PIPE];

    always_ff @(posedge clk) begin
      if (rst) begin
        for (int i = 0; i < PIPE; i++) pipe_q[i].ctrl.valid <= 1'b0;
      end else if (!stall) begin
        pipe_q[0] <= prod_entry;
        for (int i = 1; i < PIPE; i++) pipe_q[i] <= pipe_q[i-1];
      end
    end

    assign so_in = pipe_q[PIPE-1];
  end

  // Output stage: load or accumulate on a valid entry; a bubble only drops
  // out_valid and keeps acc/ovf so y stays at the last result.
  always_comb begin
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_valid_d = so_in.ctrl.valid;
    sum         = {1'b0, acc_q} + {1'b0, so_in.p};
    if (so_in.ctrl.valid) begin
      if (so_in.ctrl.acc_en) begin
        acc_d = sum[ACC_W-1:0];
        if (so_in.ctrl.is_signed) begin
          ovf_d = (acc_q[ACC_W-1] == so_in.p[ACC_W-1]) &&
                  (sum[ACC_W-1] != acc_q[ACC_W-1]);
        end else begin
          ovf_d = sum[ACC_W];
        end
      end else begin
        acc_d = so_in.p;
        ovf_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (!stall) begin
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.y         = acc_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_dadda_mac_pipe.sv
// -----------------------------------------------------------------------------
// tb_dadda_mac_pipe
// Self-checking bench for dadda_mac_pipe (WIDTH=8, PIPE=1, GUARD=4, ACC_W=20).
// Expected results are computed with integer arithmetic when an input is
// accepted, queued, and popped when the DUT transfers a result out.
// -----------------------------------------------------------------------------
module tb_dadda_mac_pipe;

  localparam int WIDTH = 8;
  localparam int PIPE  = 1;
  localparam int GUARD = 4;
  localparam int ACC_W = 20;

  typedef struct {
    logic       v;
    logic [7:0] a;
    logic [7:0] b;
    logic       s;
    logic       e;
  } txn_t;

  typedef struct {
    logic             in_rdy;
    logic             out_valid;
    logic             fire;
    logic [ACC_W-1:0] y;
    logic             ovf;
  } obs_t;

  typedef struct {
    logic [ACC_W-1:0] y;
    logic             ovf;
  } exp_t;

  logic             clk;
  logic             rst;
  int               errors = 0;
  int               checks = 0;
  exp_t             sb[$];
  logic [ACC_W-1:0] model_acc;

  dadda_mac_pipe_if #(.WIDTH(WIDTH), .GUARD(GUARD)) bus ();

  dadda_mac_pipe #(
    .WIDTH (WIDTH),
    .PIPE  (PIPE),
    .GUARD (GUARD)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic txn_t mk(input logic v, input logic [7:0] a,
                              input logic [7:0] b, input logic s,
                              input logic e);
    txn_t t;
    t.v = v; t.a = a; t.b = b; t.s = s; t.e = e;
    return t;
  endfunction

  // Reference model using plain integer arithmetic and range checks.
  function automatic exp_t model_push(input txn_t t);
    exp_t   r;
    longint pa, pb, pr, acc_s, acc_u, p_u, tot;
    logic [ACC_W-1:0] p;
    pa = t.s ? longint'($signed(t.a)) : longint'(t.a);
    pb = t.s ? longint'($signed(t.b)) : longint'(t.b);
    pr = pa * pb;
    p  = pr[ACC_W-1:0];
    if (!t.e) begin
      model_acc = p;
      r.ovf     = 1'b0;
    end else if (t.s) begin
      acc_s     = longint'($signed(model_acc));
      tot       = acc_s + longint'($signed(p));
      r.ovf     = (tot > 524287) || (tot < -524288);
      model_acc = tot[ACC_W-1:0];
    end else begin
      acc_u     = longint'(model_acc);
      p_u       = longint'(p);
      tot       = acc_u + p_u;
      r.ovf     = (tot >= 1048576);
      model_acc = tot[ACC_W-1:0];
    end
    r.y = model_acc;
    return r;
  endfunction

  // One clock cycle: drive, sample away from the edge, record accepted input.
  task automatic step(input txn_t t, input logic out_r, output obs_t o);
    bus.in_valid  = t.v;
    bus.a         = t.a;
    bus.b         = t.b;
    bus.is_signed = t.s;
    bus.acc_en    = t.e;
    bus.out_ready = out_r;
    #1;
    o.in_rdy    = bus.in_ready;
    o.out_valid = bus.out_valid;
    o.y         = bus.y;
    o.ovf       = bus.ovf;
    o.fire      = bus.out_valid && out_r;
    if (!rst && t.v && bus.in_ready) sb.push_back(model_push(t));
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb.delete();
    model_acc = '0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
    end
    checks++;
    if (bus.y !== 20'h0) begin
      errors++; $display("FAIL reset_y: got %h want 00000", bus.y);
    end
    checks++;
    if (bus.ovf !== 1'b0) begin
      errors++; $display("FAIL reset_ovf: got %b want 0", bus.ovf);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    end
    @(negedge clk);
  endtask

  task automatic test_unsigned_mul();
    obs_t o;
    exp_t e;
    int   fire_at = -1;
    for (int c = 0; c < 12; c++) begin
      step((c == 0) ? mk(1, 8'hFF, 8'hFF, 0, 0) : mk(0, 0, 0, 0, 0), 1'b1, o);
      if (o.fire) begin
        if (fire_at < 0) fire_at = c;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL umul_extra: unexpected output y=%h", o.y);
        end else begin
          e = sb.pop_front();
          if (o.y !== e.y || o.ovf !== e.ovf) begin
            errors++; $display("FAIL umul_sb: got y=%h ovf=%b want y=%h ovf=%b", o.y, o.ovf, e.y, e.ovf);
          end
        end
        checks++;
        if (o.y !== 20'h0FE01 || o.ovf !== 1'b0) begin
          errors++; $display("FAIL umul_255x255: got y=%h ovf=%b want y=0fe01 ovf=0", o.y, o.ovf);
        end
      end
    end
    checks++;
    if (fire_at != 3) begin
      errors++; $display("FAIL umul_latency: got %0d cycles want 3", fire_at);
    end
  endtask

  task automatic test_signed_mul();
    obs_t             o;
    exp_t             e;
    logic [ACC_W-1:0] want [2];
    int               n = 0;
    want[0] = 20'hFC080;
    want[1] = 20'h00001;
    for (int c = 0; c < 12; c++) begin
      if (c == 0)      step(mk(1, 8'h80, 8'h7F, 1, 0), 1'b1, o);
      else if (c == 1) step(mk(1, 8'hFF, 8'hFF, 1, 0), 1'b1, o);
      else             step(mk(0, 0, 0, 0, 0), 1'b1, o);
      if (o.fire) begin
        checks++;
        if (sb.size() == 0 || n > 1) begin
          errors++; $display("FAIL smul_extra: unexpected output y=%h", o.y);
        end else begin
          e = sb.pop_front();
          if (o.y !== e.y || o.ovf !== e.ovf || o.y !== want[n]) begin
            errors++; $display("FAIL smul_%0d: got y=%h ovf=%b want y=%h ovf=%b", n, o.y, o.ovf, want[n], e.ovf);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 2) begin
      errors++; $display("FAIL smul_count: got %0d outputs want 2", n);
    end
  endtask

  task automatic test_accum_chain();
    obs_t             o;
    exp_t             e;
    logic [ACC_W-1:0] want [3];
    int               n = 0;
    int               first = -1;
    want[0] = 20'h0FE01;
    want[1] = 20'h1FC02;
    want[2] = 20'h2FA03;
    for (int c = 0; c < 12; c++) begin
      if (c < 3) step(mk(1, 8'hFF, 8'hFF, 0, (c != 0)), 1'b1, o);
      else       step(mk(0, 0, 0, 0, 0), 1'b1, o);
      if (o.fire) begin
        if (first < 0) first = c;
        checks++;
        if (sb.size() == 0 || n > 2) begin
          errors++; $display("FAIL acc_extra: unexpected output y=%h", o.y);
        end else begin
          e = sb.pop_front();
          if (o.y !== want[n] || o.y !== e.y || o.ovf !== 1'b0 || c != first + n) begin
            errors++; $display("FAIL acc_chain_%0d: got y=%h ovf=%b cycle=%0d want y=%h ovf=0 cycle=%0d", n, o.y, o.ovf, c, want[n], first + n);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 3) begin
      errors++; $display("FAIL acc_count: got %0d outputs want 3", n);
    end
  endtask

  task automatic test_unsigned_wrap();
    obs_t o;
    exp_t e;
    int   n = 0;
    for (int c = 0; c < 30; c++) begin
      if (c < 17) step(mk(1, 8'hFF, 8'hFF, 0, (c != 0)), 1'b1, o);
      else        step(mk(0, 0, 0, 0, 0), 1'b1, o);
      if (o.fire) begin
        n++;
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL wrap_extra: unexpected output y=%h", o.y);
        end else begin
          e = sb.pop_front();
          if (o.y !== e.y || o.ovf !== e.ovf) begin
            errors++; $display("FAIL wrap_sb_%0d: got y=%h ovf=%b want y=%h ovf=%b", n, o.y, o.ovf, e.y, e.ovf);
          end
        end
        checks++;
        if (n == 17 && (o.y !== 20'h0DE11 || o.ovf !== 1'b1)) begin
          errors++; $display("FAIL wrap_17th: got y=%h ovf=%b want y=0de11 ovf=1", o.y, o.ovf);
        end else if (n < 17 && o.ovf !== 1'b0) begin
          errors++; $display("FAIL wrap_early_ovf_%0d: got ovf=%b want 0", n, o.ovf);
        end
      end
    end
    checks++;
    if (n != 17) begin
      errors++; $display("FAIL wrap_count: got %0d outputs want 17", n);
    end
  endtask

  task automatic test_backpressure();
    obs_t             o;
    exp_t             e;
    txn_t             list [5];
    int               idx = 0;
    int               n = 0;
    logic             out_r;
    logic             prev_stall = 1'b0;
    logic [ACC_W-1:0] prev_y = '0;
    list[0] = mk(1, 8'd3,   8'd5,   0, 0);
    list[1] = mk(1, 8'd200, 8'd100, 0, 1);
    list[2] = mk(1, 8'h80,  8'h80,  1, 1);
    list[3] = mk(1, 8'h7F,  8'h81,  1, 1);
    list[4] = mk(1, 8'd17,  8'd19,  0, 1);
    for (int c = 0; c < 30; c++) begin
      out_r = !(c >= 3 && c < 7);
      step((idx < 5) ? list[idx] : mk(0, 0, 0, 0, 0), out_r, o);
      if (idx < 5 && o.in_rdy) idx++;
      if (o.out_valid && !out_r) begin
        checks++;
        if (o.in_rdy !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready: cycle %0d got %b want 0", c, o.in_rdy);
        end
      end
      if (prev_stall) begin
        checks++;
        if (o.out_valid !== 1'b1 || o.y !== prev_y) begin
          errors++; $display("FAIL bp_hold: cycle %0d got valid=%b y=%h want valid=1 y=%h", c, o.out_valid, o.y, prev_y);
        end
      end
      prev_stall = o.out_valid && !out_r;
      prev_y     = o.y;
      if (o.fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL bp_extra: unexpected output y=%h", o.y);
        end else begin
          e = sb.pop_front();
          if (o.y !== e.y || o.ovf !== e.ovf) begin
            errors++; $display("FAIL bp_order_%0d: got y=%h ovf=%b want y=%h ovf=%b", n, o.y, o.ovf, e.y, e.ovf);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 5 || idx != 5 || sb.size() != 0) begin
      errors++; $display("FAIL bp_count: got %0d outputs %0d accepted want 5 and 5", n, idx);
    end
  endtask

  task automatic test_reset_mid();
    obs_t o;
    exp_t e;
    int   n = 0;
    step(mk(1, 8'd11, 8'd12, 0, 0), 1'b1, o);
    step(mk(1, 8'd13, 8'd14, 0, 1), 1'b1, o);
    rst = 1'b1;
    step(mk(1, 8'd15, 8'd16, 0, 1), 1'b1, o);
    rst = 1'b0;
    sb.delete();
    model_acc = '0;
    for (int c = 0; c < 6; c++) begin
      step(mk(0, 0, 0, 0, 0), 1'b1, o);
      checks++;
      if (o.out_valid !== 1'b0) begin
        errors++; $display("FAIL rstmid_flushed: cycle %0d got out_valid=%b want 0", c, o.out_valid);
      end
    end
    for (int c = 0; c < 10; c++) begin
      step((c == 0) ? mk(1, 8'd2, 8'd3, 0, 1) : mk(0, 0, 0, 0, 0), 1'b1, o);
      if (o.fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rstmid_extra: unexpected output y=%h", o.y);
        end else begin
          e = sb.pop_front();
          if (o.y !== 20'h00006 || o.y !== e.y || o.ovf !== 1'b0) begin
            errors++; $display("FAIL rstmid_acc_cleared: got y=%h ovf=%b want y=00006 ovf=0", o.y, o.ovf);
          end
        end
        n++;
      end
    end
    checks++;
    if (n != 1) begin
      errors++; $display("FAIL rstmid_count: got %0d outputs want 1", n);
    end
  endtask

  task automatic test_random_mix();
    obs_t o;
    exp_t e;
    int   sent = 0;
    int   n = 0;
    txn_t t;
    for (int c = 0; c < 400 && (sent < 60 || sb.size() != 0); c++) begin
      t = mk(0, 0, 0, 0, 0);
      if (sent < 60 && $urandom_range(0, 9) < 8) begin
        t = mk(1, 8'($urandom), 8'($urandom), 1'($urandom), ($urandom_range(0, 7) != 0));
      end
      step(t, ($urandom_range(0, 9) < 7), o);
      if (t.v && o.in_rdy) sent++;
      if (o.fire) begin
        checks++;
        if (sb.size() == 0) begin
          errors++; $display("FAIL rand_extra: unexpected output y=%h", o.y);
        end else begin
          e = sb.pop_front();
          if (o.y !== e.y || o.ovf !== e.ovf) begin
            errors++; $display("FAIL rand_%0d: got y=%h ovf=%b want y=%h ovf=%b", n, o.y, o.ovf, e.y, e.ovf);
          end
        end
        n++;
      end
    end
    checks++;
    if (sent != 60 || n != 60 || sb.size() != 0) begin
      errors++; $display("FAIL rand_drain: sent=%0d received=%0d pending=%0d want 60/60/0", sent, n, sb.size());
    end
  endtask

  initial begin
    rst           = 1'b1;
    model_acc     = '0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.is_signed = 1'b0;
    bus.acc_en    = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    test_reset();
    test_unsigned_mul();
    test_signed_mul();
    test_accum_chain();
    test_unsigned_wrap();
    test_backpressure();
    test_reset_mid();
    test_random_mix();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
